pipereg_stage: RTL and testbench
================================

# pipereg_stage

Parametrised pipeline stage register for the five-stage MIPS datapath, the generalised successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It registers an arbitrary-width payload plus a separately flushable control field. It advances on instruction/data hits with optional dhit gating, and supports hazard-unit stall and deferred flush (bubble insertion). One instance per stage boundary; optional per-stage event counters.

## Interface
Parameters:
- DATA_W, 96, payload width (operands, addresses, npc, dest…); zeroed on flush
- CTRL_W, 16, control width (WB/MEM control bits); zeroed on flush
- DHIT_GATE, 1, 1 = advance also driven by dhit and blocked by outstanding memory op; 0 = advance on ihit only
- CNT_W, 16, counter width (only with PIPEREG_STATS_EN)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory hit
- dhit  in  1  data memory hit
- memwait  in  1  MEM stage holds a dREN/dWEN not yet served
- stall  in  1  hazard unit hold request
- flush  in  1  branch/jump bubble request
- valid_in  in  1  upstream entry valid
- data_in  in  DATA_W  payload
- ctrl_in  in  CTRL_W  control
- valid_out  out  1  registered valid
- data_out  out  DATA_W  registered payload
- ctrl_out  out  CTRL_W  registered control
- adv  out  1  combinational: register loads this cycle
- flush_pend  out  1  registered: flush accepted but not yet applied
- stat_clr  in  1  synchronous counter clear (macro only)
- cnt_adv, cnt_stall, cnt_bubble  out  CNT_W each  event counters (macro only)

## Operation
- advance = DHIT_GATE ? (dhit | (ihit & ~memwait)) : ihit.
- adv = advance & ~stall.
- Priority each edge: reset > flush-apply > stall/hold > load.
- flush-apply condition: adv & (flush | flush_pend). Loads valid_out=0, data_out=0, ctrl_out=0; clears flush_pend.
- Load: adv & ~flush & ~flush_pend → valid_out<=valid_in, data_out<=data_in, ctrl_out<=ctrl_in.
- Hold: ~adv → all outputs keep value.
- Deferred flush: flush & ~adv → flush_pend<=1. flush_pend stays set through any number of stalled/non-advancing cycles; repeated flush while pending has no extra effect.
- stall during adv-capable cycle: register holds, flush (if asserted) becomes pending.
- dhit & ihit same cycle: single advance (no double load).

## Timing
- Reset (nRST low, any time, including mid-stall or with flush pending): valid_out=0, data_out=0, ctrl_out=0, flush_pend=0, all counters=0, immediately (asynchronous).
- Latency: one cycle from data_in to data_out on an adv cycle.
- adv is combinational from ihit/dhit/memwait/stall; no combinational path from flush to outputs.
- Pending flush applies on the first subsequent adv edge; the bubble is visible one cycle after that edge.

## Configuration
- PIPEREG_STATS_EN defined: three saturating CNT_W counters. cnt_adv increments on load edges; cnt_stall on edges with advance & stall; cnt_bubble on flush-apply edges. Saturate at all-ones. stat_clr zeros all three synchronously, overriding increment that edge. Reset to 0.
- Not defined: stat_clr and counter ports absent; no counter logic.

## Test plan
- Reset: drive data_in=all-ones, ihit=1, nRST low mid-cycle → all outputs 0 immediately; flush_pend 0.
- Load: ihit=1, stall=0, data_in=0x1234, ctrl_in=0x00FF, valid_in=1 → next cycle data_out=0x1234, ctrl_out=0x00FF, valid_out=1.
- dhit gating (DHIT_GATE=1): memwait=1, ihit=1, dhit=0 for 3 cycles → outputs hold, adv=0; dhit=1 → loads new payload next edge.
- Deferred flush: flush=1 one cycle with ihit=0 → flush_pend=1, outputs unchanged; two idle cycles; ihit=1 → valid_out=0, data_out=0, ctrl_out=0, flush_pend=0.
- Stall vs flush: stall=1, ihit=1, flush=1 → hold, flush_pend=1; stall=0 next cycle → bubble loaded, not data_in.
- Counters (macro, CNT_W=4): 20 adv cycles → cnt_adv=15 saturated; stat_clr=1 with adv → cnt_adv=0.

Source files
------------

// File: rtl/pipereg_stage.sv
// Pipeline stage register: payload plus separately flushable control, with hazard stall and deferred flush.
// Latency: one cycle from data_in to data_out on an adv edge; adv itself is combinational.
// Backpressure: stall or missing hit holds all outputs; a flush seen while held is parked in flush_pend.
// Optional event counters are built when the macro PIPEREG_STATS_EN is defined.
module pipereg_stage #(
  parameter int DATA_W    = 96,
  parameter int CTRL_W    = 16,
  parameter int DHIT_GATE = 1,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              memwait,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              adv,
  output logic              flush_pend
`ifdef PIPEREG_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  cnt_adv,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_bubble
`endif
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_flush_pend;

  logic w_advance;
  logic w_adv;
  logic w_flush_apply;
  logic w_load;

  // Advance source: with gating a data hit also advances, but an unserved memory op blocks the ihit path.
  assign w_advance     = (DHIT_GATE != 0) ? (dhit | (ihit & ~memwait)) : ihit;
  assign w_adv         = w_advance & ~stall;
  // A bubble is inserted on the first advancing edge that sees a live or parked flush.
  assign w_flush_apply = w_adv & (flush | r_flush_pend);
  assign w_load        = w_adv & ~flush & ~r_flush_pend;

  // Stage register: flush-apply beats load; a flush arriving while held is remembered until the next advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ctrl       <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_flush_apply) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ctrl       <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_load) begin
      r_valid      <= valid_in;
      r_data       <= data_in;
      r_ctrl       <= ctrl_in;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end
  end

  assign valid_out  = r_valid;
  assign data_out   = r_data;
  assign ctrl_out   = r_ctrl;
  assign adv        = w_adv;
  assign flush_pend = r_flush_pend;

`ifdef PIPEREG_STATS_EN
  logic [CNT_W-1:0] r_cnt_adv;
  logic [CNT_W-1:0] r_cnt_stall;
  logic [CNT_W-1:0] r_cnt_bubble;
  logic             w_stall_evt;

  // A stall event is an edge where the stage could have advanced but the hazard unit held it.
  assign w_stall_evt = w_advance & stall;

  // Saturating event counters; a clear wins over any increment on the same edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt_adv    <= '0;
      r_cnt_stall  <= '0;
      r_cnt_bubble <= '0;
    end else if (stat_clr) begin
      r_cnt_adv    <= '0;
      r_cnt_stall  <= '0;
      r_cnt_bubble <= '0;
    end else begin
      if (w_load && (r_cnt_adv != '1))
        r_cnt_adv <= r_cnt_adv + 1'b1;
      if (w_stall_evt && (r_cnt_stall != '1))
        r_cnt_stall <= r_cnt_stall + 1'b1;
      if (w_flush_apply && (r_cnt_bubble != '1))
        r_cnt_bubble <= r_cnt_bubble + 1'b1;
    end
  end

  assign cnt_adv    = r_cnt_adv;
  assign cnt_stall  = r_cnt_stall;
  assign cnt_bubble = r_cnt_bubble;
`else
  // CNT_W only sizes the counters, which are absent in this build.
  if (CNT_W > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_pipereg_stage.sv
// Directed bench for pipereg_stage: reset, load, dhit gating, deferred flush, stall vs flush, async reset.
// Counter checks run only when PIPEREG_STATS_EN is defined (counters built with CNT_W=4).
module tb_pipereg_stage;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              CLK;
  logic              nRST;
  logic              ihit, dhit, memwait, stall, flush, valid_in;
  logic [DATA_W-1:0] data_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic              adv;
  logic              flush_pend;
`ifdef PIPEREG_STATS_EN
  logic              stat_clr;
  logic [CNT_W-1:0]  cnt_adv, cnt_stall, cnt_bubble;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] all_ones;

  pipereg_stage #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DHIT_GATE(1), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memwait(memwait),
    .stall(stall), .flush(flush), .valid_in(valid_in), .data_in(data_in),
    .ctrl_in(ctrl_in), .valid_out(valid_out), .data_out(data_out),
    .ctrl_out(ctrl_out), .adv(adv), .flush_pend(flush_pend)
`ifdef PIPEREG_STATS_EN
    , .stat_clr(stat_clr), .cnt_adv(cnt_adv), .cnt_stall(cnt_stall), .cnt_bubble(cnt_bubble)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                           input logic [CTRL_W-1:0] c, input logic p);
    check({tag, ".valid"}, {127'd0, valid_out}, {127'd0, v});
    check({tag, ".data"}, {32'd0, data_out}, {32'd0, d});
    check({tag, ".ctrl"}, {112'd0, ctrl_out}, {112'd0, c});
    check({tag, ".pend"}, {127'd0, flush_pend}, {127'd0, p});
  endtask

  initial begin
    all_ones = '1;
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; memwait = 1'b0; stall = 1'b0;
    flush = 1'b0; valid_in = 1'b0; data_in = '0; ctrl_in = '0;
`ifdef PIPEREG_STATS_EN
    stat_clr = 1'b0;
`endif
    step(); step();
    check_out("reset", 1'b0, '0, '0, 1'b0);
    nRST = 1'b1;
    step();

    // Plain load
    ihit = 1'b1; valid_in = 1'b1; data_in = 96'h1234; ctrl_in = 16'h00FF;
    #1 check("load.adv", {127'd0, adv}, 128'd1);
    step();
    check_out("load", 1'b1, 96'h1234, 16'h00FF, 1'b0);

    // Outstanding memory op blocks ihit advance until dhit arrives
    memwait = 1'b1; dhit = 1'b0; data_in = 96'hABCD; ctrl_in = 16'h0F0F;
    #1 check("gate.adv0", {127'd0, adv}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("gate.hold", 1'b1, 96'h1234, 16'h00FF, 1'b0);
    end
    dhit = 1'b1;
    #1 check("gate.adv1", {127'd0, adv}, 128'd1);
    step();
    check_out("gate.load", 1'b1, 96'hABCD, 16'h0F0F, 1'b0);

    // Deferred flush: parked while idle, applied on first advance
    ihit = 1'b0; dhit = 1'b0; memwait = 1'b0; flush = 1'b1; data_in = 96'h5555; ctrl_in = 16'h1111;
    step();
    check_out("dflush.park", 1'b1, 96'hABCD, 16'h0F0F, 1'b1);
    step();   // repeated flush while pending changes nothing
    check_out("dflush.again", 1'b1, 96'hABCD, 16'h0F0F, 1'b1);
    flush = 1'b0;
    step(); step();
    check_out("dflush.idle", 1'b1, 96'hABCD, 16'h0F0F, 1'b1);
    ihit = 1'b1;
    step();
    check_out("dflush.bubble", 1'b0, '0, '0, 1'b0);
    step();
    check_out("dflush.resume", 1'b1, 96'h5555, 16'h1111, 1'b0);

    // Stall with flush: hold and park, bubble on release instead of data_in
    stall = 1'b1; flush = 1'b1; data_in = 96'h7777; ctrl_in = 16'h2222;
    #1 check("sf.adv", {127'd0, adv}, 128'd0);
    step();
    check_out("sf.hold", 1'b1, 96'h5555, 16'h1111, 1'b1);
    stall = 1'b0; flush = 1'b0;
    step();
    check_out("sf.bubble", 1'b0, '0, '0, 1'b0);

    // Async reset mid-cycle with a flush pending
    data_in = all_ones; ctrl_in = 16'hFFFF;
    step();
    check_out("pre_rst.load", 1'b1, all_ones, 16'hFFFF, 1'b0);
    stall = 1'b1; flush = 1'b1;
    step();
    check_out("pre_rst.park", 1'b1, all_ones, 16'hFFFF, 1'b1);
    #2 nRST = 1'b0;
    #1 check_out("async_rst", 1'b0, '0, '0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    step();
    nRST = 1'b1;

`ifdef PIPEREG_STATS_EN
    // Counters cleared by reset
    check("cnt.rst", {124'd0, cnt_adv}, 128'd0);
    // 20 load edges saturate a 4-bit counter
    for (int i = 0; i < 20; i++) step();
    check("cnt.adv_sat", {124'd0, cnt_adv}, 128'd15);
    stall = 1'b1;
    step(); step(); step();
    check("cnt.stall", {124'd0, cnt_stall}, 128'd3);
    stall = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("cnt.bubble", {124'd0, cnt_bubble}, 128'd1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("cnt.clr_adv", {124'd0, cnt_adv}, 128'd0);
    check("cnt.clr_bub", {124'd0, cnt_bubble}, 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
